// File: rtl/csa_word_sequencer_pkg.sv
// csa_word_sequencer_pkg: shared FSM state encoding and nibble width for the serial adder.
package csa_word_sequencer_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/csa_word_sequencer_csa4.sv
// csa_word_sequencer_csa4: combinational 4-bit carry-select slice, both carry cases precomputed.
module csa_word_sequencer_csa4
  import csa_word_sequencer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);
  logic [NIBBLE_W:0]   s0, s1;
  logic [NIBBLE_W-1:0] l0, l1;
  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, 1'b1};
  // c3 is the carry into the slice MSB, needed for signed overflow on the top nibble
  assign l0 = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]};
  assign l1 = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]} + {{(NIBBLE_W-1){1'b0}}, 1'b1};
  assign {co, s} = c ? s1 : s0;
  assign c3 = c ? l1[NIBBLE_W-1] : l0[NIBBLE_W-1];
endmodule

// File: rtl/csa_word_sequencer.sv
// csa_word_sequencer: nibble-serial add/subtract through one shared carry-select slice.
module csa_word_sequencer
  import csa_word_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic carry, nc, n3;
  logic [NIBBLE_W-1:0] ns;
  logic accept;
  assign accept = in_valid && in_ready;
  csa_word_sequencer_csa4 csa4 (
    .a (op_a[cnt*NIBBLE_W +: NIBBLE_W]),
    .b (op_b[cnt*NIBBLE_W +: NIBBLE_W]),
    .c (carry),
    .s (ns),
    .co(nc),
    .c3(n3)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (accept ? RUN : IDLE) :
          state == RUN  ? (cnt == LAST ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE && !rst;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && accept) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum[cnt*NIBBLE_W +: NIBBLE_W] <= ns;
      carry <= nc;
      if (cnt == LAST) begin
        cout <= nc;
        ovf  <= nc ^ n3;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: doc/csa_word_sequencer.md
CSA_WORD_SEQUENCER -- requirements
Module: csa_word_sequencer

Interface
REQ-001: Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: in_valid  input  1  requester presents an operation.
REQ-005: in_ready  output  1  block can accept an operation.
REQ-006: a  input  WIDTH  operand A.
REQ-007: b  input  WIDTH  operand B.
REQ-008: cin  input  1  carry-in for add; ignored for subtract.
REQ-009: sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-010: out_valid  output  1  result available.
REQ-011: out_ready  input  1  consumer accepts result.
REQ-012: sum  output  WIDTH  result word.
REQ-013: cout  output  1  carry out of the MSB nibble.
REQ-014: ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-015: Block SHALL compute the WIDTH-bit result serially, one 4-bit nibble per cycle, LSB nibble first, through a single shared 4-bit carry-select slice; NIBBLES = WIDTH/4.
REQ-016: FSM states SHALL be IDLE, RUN, DONE.
- IDLE -> RUN on in_valid & in_ready.
- RUN -> DONE when the last nibble is processed.
- DONE -> IDLE on out_valid & out_ready.
REQ-017: in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018: On accept (cycle 0), a, b^{sub replicated}, and the initial carry (sub ? 1 : cin) SHALL be latched; later input changes have no effect.
REQ-019: In RUN cycle i+1 (i = 0..NIBBLES-1), nibble i SHALL be summed with the registered carry; the nibble result is written into sum[4i+3:4i] and the slice carry-out registered as the next carry.
REQ-020: Latency SHALL be fixed: out_valid asserted in cycle NIBBLES+1 after the accept cycle (cycle 5 for WIDTH=16), independent of data.
REQ-021: cout SHALL equal the carry out of nibble NIBBLES-1; ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-022: sum, cout, ovf SHALL hold stable while out_valid=1 and out_ready=0 (unbounded backpressure).
REQ-023: in_valid while in_ready=0 SHALL be ignored (no queuing); out_ready while out_valid=0 SHALL be ignored.
REQ-024: A new operation SHALL NOT be accepted in the same cycle a result is consumed; earliest re-accept is the cycle after DONE -> IDLE (throughput one op per NIBBLES+2 cycles).
REQ-025: Nibble counter SHALL wrap only through IDLE; it SHALL NOT exceed NIBBLES-1.

Reset
REQ-026: rst=1 SHALL immediately force state IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0; in_ready becomes 1 once rst deasserts.
REQ-027: Reset asserted during RUN or DONE SHALL abandon the operation with no result ever presented.

Structure
REQ-028: Shared package SHALL hold the FSM state enum and the NIBBLE_W=4 constant; NIBBLES derived locally from WIDTH.
REQ-029: The shared datapath SHALL be one sub-module instance csa4: combinational 4-bit carry-select slice (two precomputed ripple sums for carry 0/1, selected by the registered carry); csa4 has no clock.

Verification
REQ-030: WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> out_valid in cycle 5, sum=0x5555, cout=0, ovf=0.
REQ-031: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0.
REQ-032: a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-033: out_ready held 0 for 3 cycles after out_valid -> sum/cout/ovf unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-034: rst asserted in RUN cycle 2 -> outputs zero immediately; after release, in_ready=1, out_valid never asserted for the abandoned op; next op a=0x0001, b=0x0001 -> sum=0x0002.
